// File: rtl/mem_stage_pkg.sv
// Shared decode patterns, instruction bit positions and state encoding for the
// memory stage and its load-alignment helper.
package mem_stage_pkg;

  localparam int BIT_P = 24;
  localparam int BIT_U = 23;
  localparam int BIT_B = 22;
  localparam int BIT_W = 21;
  localparam int BIT_L = 20;

  localparam logic [31:0] DECODE_LDRSTR_MASK           = 32'h0C00_0000;
  localparam logic [31:0] DECODE_LDRSTR                = 32'h0400_0000;
  localparam logic [31:0] DECODE_LDRSTR_UNDEFINED_MASK = 32'h0600_0010;
  localparam logic [31:0] DECODE_LDRSTR_UNDEFINED      = 32'h0600_0010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // A register-offset form with bit 4 set is an undefined encoding, not a transfer.
  function automatic logic isLdrStr(input logic [31:0] insn);
    return ((insn & DECODE_LDRSTR_MASK) == DECODE_LDRSTR) &&
           ((insn & DECODE_LDRSTR_UNDEFINED_MASK) != DECODE_LDRSTR_UNDEFINED);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load-data alignment: byte lane select with zero-extend, and word rotation
// for unaligned word loads when MEM_ROTATE_EN is defined.
module mem_load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addrLo,
  input  logic        i_byte,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    if (i_byte) begin
      case (i_addrLo)
        2'd0:    o_data = {24'h0, i_rdata[7:0]};
        2'd1:    o_data = {24'h0, i_rdata[15:8]};
        2'd2:    o_data = {24'h0, i_rdata[23:16]};
        default: o_data = {24'h0, i_rdata[31:24]};
      endcase
    end else begin
`ifdef MEM_ROTATE_EN
      case (i_addrLo)
        2'd0:    o_data = i_rdata;
        2'd1:    o_data = {i_rdata[7:0],  i_rdata[31:8]};
        2'd2:    o_data = {i_rdata[15:0], i_rdata[31:16]};
        default: o_data = {i_rdata[23:0], i_rdata[31:24]};
      endcase
`else
      o_data = i_rdata;
`endif
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: LDR/STR (word/byte) over a req/ack bus, with
// pass-through of non-memory instructions. Optional macro: MEM_ROTATE_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              inbubble,
  input  logic [31:0]       pc,
  input  logic [31:0]       insn,
  input  logic [31:0]       op0,
  input  logic [31:0]       op1,
  input  logic [31:0]       op2,
  input  logic              inwrite_reg,
  input  logic [3:0]        inwrite_num,
  input  logic [31:0]       inwrite_data,
  input  logic [31:0]       incpsr,
  output logic              outstall,
  output logic              outbubble,
  output logic [31:0]       outpc,
  output logic [31:0]       outinsn,
  output logic [31:0]       outcpsr,
  output logic              write_reg,
  output logic [3:0]        write_num,
  output logic [31:0]       write_data,
  output logic              base_reg,
  output logic [3:0]        base_num,
  output logic [31:0]       base_data,
  output logic              jmp,
  output logic [31:0]       jmppc,
  output logic              bus_req,
  output logic              bus_wr,
  output logic              bus_byte,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_t      r_state;
  logic [31:0] r_pc, r_insn, r_cpsr, r_offAddr, r_rdata;
  logic [1:0]  r_addrLo;
  logic        r_flushed;

  logic        w_memOp, w_emitNow, w_squash, w_isLoad, w_baseWb, w_outStall;
  logic [31:0] w_offAddr, w_addr, w_rawData, w_loadData;
  logic [3:0]  w_rd, w_rn;

  assign w_memOp   = !inbubble && isLdrStr(insn);
  assign w_offAddr = insn[BIT_U] ? (op0 + op1) : (op0 - op1);
  assign w_addr    = insn[BIT_P] ? w_offAddr : op0;

  assign w_rd      = r_insn[15:12];
  assign w_rn      = r_insn[19:16];
  assign w_isLoad  = r_insn[BIT_L];
  assign w_baseWb  = !r_insn[BIT_P] || r_insn[BIT_W];
  assign w_squash  = r_flushed || flush;
  assign w_emitNow = ((r_state == ACCESS) && bus_ack && !stall) ||
                     ((r_state == HOLD) && !stall);
  assign w_rawData = (r_state == HOLD) ? r_rdata : bus_rdata;

  mem_load_align u_align (
    .i_rdata  (w_rawData),
    .i_addrLo (r_addrLo),
    .i_byte   (r_insn[BIT_B]),
    .o_data   (w_loadData)
  );

  // Upstream holds while an access is pending; it releases in the cycle the result is emitted.
  always_comb begin
    w_outStall = 1'b0;
    case (r_state)
      IDLE:    w_outStall = w_memOp && !flush;
      ACCESS:  w_outStall = !(bus_ack && !stall);
      HOLD:    w_outStall = stall;
      default: w_outStall = 1'b0;
    endcase
  end

  assign outstall = w_outStall;

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_insn     <= '0;
      r_cpsr     <= '0;
      r_offAddr  <= '0;
      r_rdata    <= '0;
      r_addrLo   <= '0;
      r_flushed  <= 1'b0;
      outbubble  <= 1'b1;
      outpc      <= '0;
      outinsn    <= '0;
      outcpsr    <= '0;
      write_reg  <= 1'b0;
      write_num  <= '0;
      write_data <= '0;
      base_reg   <= 1'b0;
      base_num   <= '0;
      base_data  <= '0;
      jmp        <= 1'b0;
      jmppc      <= '0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_byte   <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (!stall) begin
          if (w_memOp && !flush) begin
            r_state   <= ACCESS;
            r_pc      <= pc;
            r_insn    <= insn;
            r_cpsr    <= incpsr;
            r_offAddr <= w_offAddr;
            r_addrLo  <= w_addr[1:0];
            r_flushed <= 1'b0;
            bus_req   <= 1'b1;
            bus_wr    <= !insn[BIT_L];
            bus_byte  <= insn[BIT_B];
            bus_addr  <= insn[BIT_B] ? w_addr : {w_addr[31:2], 2'b00};
            bus_wdata <= insn[BIT_B] ? {4{op2[7:0]}} : op2;
            outbubble <= 1'b1;
            write_reg <= 1'b0;
            base_reg  <= 1'b0;
            jmp       <= 1'b0;
          end else begin
            outbubble  <= inbubble || flush;
            outpc      <= pc;
            outinsn    <= insn;
            outcpsr    <= incpsr;
            write_reg  <= inwrite_reg;
            write_num  <= inwrite_num;
            write_data <= inwrite_data;
            base_reg   <= 1'b0;
            jmp        <= 1'b0;
          end
        end
        ACCESS: begin
          if (flush) r_flushed <= 1'b1;
          if (!stall) begin
            outbubble <= 1'b1;
            write_reg <= 1'b0;
            base_reg  <= 1'b0;
            jmp       <= 1'b0;
          end
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_wr  <= 1'b0;
            r_rdata <= bus_rdata;
            r_state <= stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (flush) r_flushed <= 1'b1;
          if (!stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A load result write to the base register takes priority over the writeback.
      if (w_emitNow) begin
        outbubble  <= w_squash;
        outpc      <= r_pc;
        outinsn    <= r_insn;
        outcpsr    <= r_cpsr;
        write_reg  <= w_isLoad && !w_squash && (w_rd != 4'd15);
        write_num  <= w_rd;
        write_data <= w_loadData;
        base_reg   <= !w_squash && w_baseWb && !(w_isLoad && (w_rn == w_rd));
        base_num   <= w_rn;
        base_data  <= r_offAddr;
        jmp        <= w_isLoad && !w_squash && (w_rd == 4'd15);
        jmppc      <= {w_loadData[31:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a transaction-level
// model of the load/store and pass-through rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        Nrst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, inbubble = 1'b1;
  logic [31:0] pc = '0, insn = '0, op0 = '0, op1 = '0, op2 = '0, incpsr = '0;
  logic        inwrite_reg = 1'b0;
  logic [3:0]  inwrite_num = '0;
  logic [31:0] inwrite_data = '0;
  logic        outstall, outbubble, write_reg, base_reg, jmp;
  logic [31:0] outpc, outinsn, outcpsr, write_data, base_data, jmppc;
  logic [3:0]  write_num, base_num;
  logic        bus_req, bus_wr, bus_byte;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .Nrst(Nrst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .pc(pc), .insn(insn), .op0(op0), .op1(op1), .op2(op2),
    .inwrite_reg(inwrite_reg), .inwrite_num(inwrite_num), .inwrite_data(inwrite_data),
    .incpsr(incpsr), .outstall(outstall), .outbubble(outbubble),
    .outpc(outpc), .outinsn(outinsn), .outcpsr(outcpsr),
    .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
    .base_reg(base_reg), .base_num(base_num), .base_data(base_data),
    .jmp(jmp), .jmppc(jmppc), .bus_req(bus_req), .bus_wr(bus_wr), .bus_byte(bus_byte),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one non-memory (or squashed/bubbled) slot and check it one cycle later.
  task automatic applyPassThrough(input logic [31:0] iInsn, input bit bub, input bit fl);
    logic [31:0] iPc, iCpsr, iData;
    logic [3:0]  iNum;
    logic        iWr;
    iPc = $urandom; iCpsr = $urandom; iData = $urandom;
    iNum = 4'($urandom_range(0, 15)); iWr = 1'($urandom_range(0, 1));
    pc = iPc; insn = iInsn; incpsr = iCpsr; op0 = $urandom; op1 = $urandom; op2 = $urandom;
    inwrite_reg = iWr; inwrite_num = iNum; inwrite_data = iData;
    inbubble = bub; flush = fl; stall = 1'b0;
    #1 checkOutput("passOutstall", 32'(outstall), 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("passBubble", 32'(outbubble), 32'(bub | fl));
    checkOutput("passPc", outpc, iPc);
    checkOutput("passInsn", outinsn, iInsn);
    checkOutput("passCpsr", outcpsr, iCpsr);
    checkOutput("passWriteReg", 32'(write_reg), 32'(iWr));
    checkOutput("passWriteNum", 32'(write_num), 32'(iNum));
    checkOutput("passWriteData", write_data, iData);
    checkOutput("passBaseReg", 32'(base_reg), 32'd0);
    checkOutput("passJmp", 32'(jmp), 32'd0);
  endtask

  // Run one LDR/STR through the bus with a given ack delay, downstream stall and flush.
  task automatic applyStimulus(input logic [31:0] iInsn, input logic [31:0] iOp0, input logic [31:0] iOp1,
                               input logic [31:0] iOp2, input logic [31:0] iRdata,
                               input int ackDelay, input int stallCycles, input bit doFlush);
    logic        p, u, b, w, l;
    logic [3:0]  rn, rd;
    logic [31:0] offAddr, addr, expBusAddr, expWdata, loadVal, iPc, iCpsr;
    int          lane;
    bit          expWriteReg, expJmp, expBase;
    p = iInsn[24]; u = iInsn[23]; b = iInsn[22]; w = iInsn[21]; l = iInsn[20];
    rn = iInsn[19:16]; rd = iInsn[15:12];
    offAddr    = u ? iOp0 + iOp1 : iOp0 - iOp1;
    addr       = p ? offAddr : iOp0;
    expBusAddr = b ? addr : addr - (addr % 32'd4);
    expWdata   = b ? 32'(iOp2[7:0]) * 32'h0101_0101 : iOp2;
    lane       = int'(addr % 32'd4);
    if (b) loadVal = (iRdata >> (8 * lane)) & 32'hFF;
    else begin
      loadVal = iRdata;
`ifdef MEM_ROTATE_EN
      if (lane != 0) loadVal = (iRdata >> (8 * lane)) | (iRdata << (32 - 8 * lane));
`endif
    end
    expWriteReg = l && !doFlush && (rd != 4'd15);
    expJmp      = l && !doFlush && (rd == 4'd15);
    expBase     = !doFlush && (!p || w) && !(l && rn == rd);

    iPc = $urandom; iCpsr = $urandom;
    pc = iPc; insn = iInsn; incpsr = iCpsr; op0 = iOp0; op1 = iOp1; op2 = iOp2;
    inbubble = 1'b0; flush = 1'b0; stall = 1'b0;
    inwrite_reg = 1'($urandom_range(0, 1)); inwrite_num = 4'($urandom_range(0, 15)); inwrite_data = $urandom;
    #1 checkOutput("acceptOutstall", 32'(outstall), 32'd1);
    tick();
    flush = doFlush;
    for (int i = 0; i <= ackDelay; i++) begin
      checkOutput("busReq", 32'(bus_req), 32'd1);
      checkOutput("busAddr", bus_addr, expBusAddr);
      checkOutput("busWr", 32'(bus_wr), 32'(!l));
      checkOutput("busByte", 32'(bus_byte), 32'(b));
      if (!l) checkOutput("busWdata", bus_wdata, expWdata);
      checkOutput("accessBubble", 32'(outbubble), 32'd1);
      if (i == ackDelay) begin
        bus_ack = 1'b1; bus_rdata = iRdata; stall = (stallCycles > 0);
      end
      #1 checkOutput("accessOutstall", 32'(outstall), (i == ackDelay && stallCycles == 0) ? 32'd0 : 32'd1);
      tick();
      flush = 1'b0;
    end
    bus_ack = 1'b0; bus_rdata = $urandom;
    for (int k = 1; k < stallCycles; k++) begin
      checkOutput("holdBubble", 32'(outbubble), 32'd1);
      checkOutput("holdReq", 32'(bus_req), 32'd0);
      checkOutput("holdOutstall", 32'(outstall), 32'd1);
      tick();
    end
    if (stallCycles > 0) begin
      stall = 1'b0;
      tick();
    end
    checkOutput("emitBubble", 32'(outbubble), 32'(doFlush));
    checkOutput("emitWriteReg", 32'(write_reg), 32'(expWriteReg));
    if (expWriteReg) begin
      checkOutput("emitWriteNum", 32'(write_num), 32'(rd));
      checkOutput("emitWriteData", write_data, loadVal);
    end
    checkOutput("emitBaseReg", 32'(base_reg), 32'(expBase));
    if (expBase) begin
      checkOutput("emitBaseNum", 32'(base_num), 32'(rn));
      checkOutput("emitBaseData", base_data, offAddr);
    end
    checkOutput("emitJmp", 32'(jmp), 32'(expJmp));
    if (expJmp) checkOutput("emitJmpPc", jmppc, loadVal - (loadVal % 32'd4));
    if (!doFlush) begin
      checkOutput("emitPc", outpc, iPc);
      checkOutput("emitInsn", outinsn, iInsn);
      checkOutput("emitCpsr", outcpsr, iCpsr);
    end
  endtask

  function automatic logic [31:0] randNonMem();
    logic [31:0] r;
    r = $urandom;
    if (r[27:26] == 2'b01) begin
      r[25] = 1'b1;
      r[4]  = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] randMemOp();
    logic [31:0] r;
    r = $urandom;
    r[27:26] = 2'b01;
    if (r[25]) r[4] = 1'b0;
    return r;
  endfunction

  initial begin
    #1 Nrst = 1'b0;
    #2;
    checkOutput("rstBubble", 32'(outbubble), 32'd1);
    checkOutput("rstWriteReg", 32'(write_reg), 32'd0);
    checkOutput("rstBaseReg", 32'(base_reg), 32'd0);
    checkOutput("rstJmp", 32'(jmp), 32'd0);
    checkOutput("rstBusReq", 32'(bus_req), 32'd0);
    checkOutput("rstBusWr", 32'(bus_wr), 32'd0);
    checkOutput("rstOutstall", 32'(outstall), 32'd0);
    checkOutput("rstOutPc", outpc, 32'd0);
    checkOutput("rstJmpPc", jmppc, 32'd0);
    #20 Nrst = 1'b1;

    applyStimulus(32'hE5B2_1004, 32'h1000, 32'h4, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);
    applyStimulus(32'hE444_3001, 32'h2003, 32'h1, 32'h1234_56AB, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'hE590_F000, 32'h100, 32'h0, 32'h0, 32'h0000_8003, 0, 0, 1'b0);
    applyPassThrough(32'hE082_1003, 1'b1, 1'b0);
    applyStimulus(32'hE596_5008, 32'h3000, 32'h8, 32'h0, 32'hCAFE_F00D, 5, 3, 1'b0);
    applyStimulus(32'hE5B8_7010, 32'h4000, 32'h10, 32'h0, 32'h1111_2222, 2, 0, 1'b1);
    applyPassThrough(32'hE082_1003, 1'b0, 1'b0);

    // Abandon an access with reset, then confirm the next instruction is accepted.
    pc = 32'h500; insn = 32'hE591_2000; op0 = 32'h6000; op1 = 32'h0; inbubble = 1'b0;
    tick();
    checkOutput("rstPreReq", 32'(bus_req), 32'd1);
    Nrst = 1'b0;
    #1;
    checkOutput("rstMidReq", 32'(bus_req), 32'd0);
    checkOutput("rstMidBubble", 32'(outbubble), 32'd1);
    #2 Nrst = 1'b1;
    inbubble = 1'b1;
    applyStimulus(32'hE5B2_1004, 32'h1000, 32'h4, 32'h0, 32'h0BAD_F00D, 1, 0, 1'b0);

    // A memory op arriving under downstream stall must not start an access.
    applyPassThrough(32'hE082_1003, 1'b0, 1'b0);
    begin
      logic [31:0] heldPc;
      heldPc = outpc;
      pc = 32'h700; insn = 32'hE591_3000; op0 = 32'h7000; op1 = 32'h0; inbubble = 1'b0; stall = 1'b1;
      tick();
      tick();
      checkOutput("idleStallReq", 32'(bus_req), 32'd0);
      checkOutput("idleStallPc", outpc, heldPc);
      checkOutput("idleStallBubble", 32'(outbubble), 32'd0);
      stall = 1'b0;
    end
    applyStimulus(32'hE591_3000, 32'h7000, 32'h0, 32'h0, 32'h7777_7777, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: applyPassThrough(randNonMem(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        1: if ($urandom_range(0, 1) == 1) applyPassThrough(randMemOp(), 1'b1, 1'($urandom_range(0, 1)));
           else applyPassThrough(randMemOp(), 1'b0, 1'b1);
        default: applyStimulus(randMemOp(), $urandom, $urandom, $urandom, $urandom,
                               $urandom_range(0, 3),
                               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                               ($urandom_range(0, 7) == 0));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
